vga_timing_gen: RTL and testbench

//  - Consumes the 25 MHz pixel clock produced by the system clock divider and generates 640x480@60 VGA timing.
//  - Runs entirely on the 100 MHz clk. The clk25 input is sampled as data, and its rising edge is converted into a one-clk pixel tick.
//  - Drives hsync/vsync to the connector and supplies pixel_x/pixel_y/video_on to the pixel-colour logic downstream.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing_gen_counter.sv | 24 ++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and coordinate type.
// Used by the VGA timing generator and its wrap counters.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam logic DEF_SYNC_POL = 1'b0;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FRONT +
    DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FRONT +
    DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_HS_START =
    DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int DEF_HS_END =
    DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START =
    DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int DEF_VS_END =
    DEF_VS_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_timing_gen_counter.sv
// vga_wrap_counter: enabled up-counter that returns to zero after
// reaching its last value, flagging the wrap combinationally.
module vga_wrap_counter
  import vga_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  coord_t last,
  output coord_t count,
  output logic   wrap
);

  assign wrap = en && (count == last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/position generator on the system clock,
// advancing one pixel per rising edge of the sampled clk25 input.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clk25,
  output logic   pix_tick,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   frame_start
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS  = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS  = coord_t'(V_ACTIVE);

  localparam coord_t HS_START =
    coord_t'(H_ACTIVE + H_FRONT);
  localparam coord_t HS_END =
    coord_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam coord_t VS_START =
    coord_t'(V_ACTIVE + V_FRONT);
  localparam coord_t VS_END =
    coord_t'(V_ACTIVE + V_FRONT + V_SYNC);

  logic   clk25_q;
  logic   tick_i;
  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap;
  logic   v_wrap;
  logic   hs_on;
  logic   vs_on;
  logic   vis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk25_q <= 1'b0;
    end else begin
      clk25_q <= clk25;
    end
  end

  assign tick_i = clk25 & ~clk25_q;

  vga_wrap_counter u_h (
    .clk   (clk),
    .reset (reset),
    .en    (tick_i),
    .last  (H_LAST),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  // v only moves on the tick that ends a line
  vga_wrap_counter u_v (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .last  (V_LAST),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  always_comb begin
    hs_on = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_on = (v_cnt >= VS_START) && (v_cnt < VS_END);
    vis   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_tick    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick_i;
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      video_on    <= vis;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vectors for a full-size 640x480 instance
// and a shrunken, positive-polarity instance sharing the same clk25.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic clk25;

  logic       bt, bhs, bvs, bvo, bfs;
  logic [9:0] bx, by;
  logic       st, shs, svs, svo, sfs;
  logic [9:0] sx, sy;

  always #5 clk = ~clk;

  vga_timing_gen u_big (
    .clk         (clk),
    .reset       (reset),
    .clk25       (clk25),
    .pix_tick    (bt),
    .hsync       (bhs),
    .vsync       (bvs),
    .video_on    (bvo),
    .pixel_x     (bx),
    .pixel_y     (by),
    .frame_start (bfs)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FRONT  (2),
    .H_SYNC   (3),
    .H_BACK   (3),
    .V_ACTIVE (4),
    .V_FRONT  (2),
    .V_SYNC   (2),
    .V_BACK   (2),
    .SYNC_POL (1'b1)
  ) u_sm (
    .clk         (clk),
    .reset       (reset),
    .clk25       (clk25),
    .pix_tick    (st),
    .hsync       (shs),
    .vsync       (svs),
    .video_on    (svo),
    .pixel_x     (sx),
    .pixel_y     (sy),
    .frame_start (sfs)
  );

  typedef struct {
    int         p;
    bit         s;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       fs;
  } vec_t;

  vec_t tbl[$];

  int total = 0;
  int bad = 0;
  int tick_idx = -1;
  int fs_cnt = 0;
  int div = 0;
  bit div_run = 1'b0;
  bit chk_per = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (div_run) begin
        div++;
        clk25 = div[1];
      end
    end
  end

  always @(negedge clk) begin
    if (sfs === 1'b1) fs_cnt++;
  end

  function automatic vec_t mk(
    int p, bit s, int x, int y,
    bit hs, bit vs, bit vo, bit fs);
    vec_t v;
    v.p  = p;
    v.s  = s;
    v.x  = 10'(x);
    v.y  = 10'(y);
    v.hs = hs;
    v.vs = vs;
    v.vo = vo;
    v.fs = fs;
    return v;
  endfunction

  function automatic logic [24:0] big_o();
    return {bx, by, bhs, bvs, bvo, bfs, bt};
  endfunction

  function automatic logic [24:0] sm_o();
    return {sx, sy, shs, svs, svo, sfs, st};
  endfunction

  task automatic check(
    string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic next_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        total++;
        bad++;
        $display("FAIL tick_timeout waited=%0d want<=40", n);
        finish_now();
      end
    end while (bt !== 1'b1);
    tick_idx++;
    if (chk_per) check("tick_period", n, 4);
  endtask

  initial begin
    int n;
    int ticks;
    vec_t v;
    logic [24:0] want;
    logic [24:0] got;

    // fields: p, small?, x, y, hs, vs, vo, fs
    tbl.push_back(mk(0,    0, 0,   0, 1, 1, 1, 0));
    tbl.push_back(mk(0,    1, 0,   0, 0, 0, 1, 0));
    tbl.push_back(mk(1,    0, 1,   0, 1, 1, 1, 0));
    tbl.push_back(mk(8,    1, 8,   0, 0, 0, 0, 0));
    tbl.push_back(mk(10,   1, 10,  0, 1, 0, 0, 0));
    tbl.push_back(mk(12,   1, 12,  0, 1, 0, 0, 0));
    tbl.push_back(mk(13,   1, 13,  0, 0, 0, 0, 0));
    tbl.push_back(mk(15,   1, 15,  0, 0, 0, 0, 0));
    tbl.push_back(mk(16,   1, 0,   1, 0, 0, 1, 0));
    tbl.push_back(mk(64,   1, 0,   4, 0, 0, 0, 0));
    tbl.push_back(mk(96,   1, 0,   6, 0, 1, 0, 0));
    tbl.push_back(mk(127,  1, 15,  7, 0, 1, 0, 0));
    tbl.push_back(mk(128,  1, 0,   8, 0, 0, 0, 0));
    tbl.push_back(mk(159,  1, 15,  9, 0, 0, 0, 1));
    tbl.push_back(mk(160,  1, 0,   0, 0, 0, 1, 0));
    tbl.push_back(mk(319,  1, 15,  9, 0, 0, 0, 1));
    tbl.push_back(mk(639,  0, 639, 0, 1, 1, 1, 0));
    tbl.push_back(mk(640,  0, 640, 0, 1, 1, 0, 0));
    tbl.push_back(mk(655,  0, 655, 0, 1, 1, 0, 0));
    tbl.push_back(mk(656,  0, 656, 0, 0, 1, 0, 0));
    tbl.push_back(mk(751,  0, 751, 0, 0, 1, 0, 0));
    tbl.push_back(mk(752,  0, 752, 0, 1, 1, 0, 0));
    tbl.push_back(mk(799,  0, 799, 0, 1, 1, 0, 0));
    tbl.push_back(mk(800,  0, 0,   1, 1, 1, 1, 0));
    tbl.push_back(mk(2256, 0, 656, 2, 0, 1, 0, 0));

    reset = 1'b1;
    clk25 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_big", big_o(), {10'd0, 10'd0, 5'b11000});
    check("rst_sm", sm_o(), {10'd0, 10'd0, 5'b00000});

    @(negedge clk);
    reset = 1'b0;
    div = 0;
    div_run = 1'b1;
    next_tick(n);
    check("first_tick_le4", 32'(n <= 4), 1);
    chk_per = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i];
      while (tick_idx < v.p) next_tick(n);
      want = {v.x, v.y, v.hs, v.vs, v.vo, v.fs, 1'b1};
      got = v.s ? sm_o() : big_o();
      check(v.s ? $sformatf("vec_sm_p%0d", v.p)
                : $sformatf("vec_big_p%0d", v.p),
            got, want);
    end

    // clk25 stuck low mid-line inside the hsync pulse
    chk_per = 1'b0;
    div_run = 1'b0;
    clk25 = 1'b0;
    ticks = 0;
    repeat (100) begin
      @(negedge clk);
      if (bt === 1'b1) ticks++;
    end
    check("hold_ticks", ticks, 0);
    check("hold_x", bx, 657);
    check("hold_y", by, 2);
    check("hold_hs", bhs, 0);

    div = 1;
    div_run = 1'b1;
    next_tick(n);
    check("resume_lat_le4", 32'(n <= 4), 1);
    check("resume_pos", {bx, by}, {10'd657, 10'd2});
    chk_per = 1'b1;

    while (tick_idx < 2700) next_tick(n);
    check("pre_rst_pos", {bx, by}, {10'd300, 10'd3});
    check("sm_frame_pulses", fs_cnt, 16);

    // reset mid-frame, between clock edges
    #1 reset = 1'b1;
    #1;
    check("arst_big", big_o(), {10'd0, 10'd0, 5'b11000});
    check("arst_sm", sm_o(), {10'd0, 10'd0, 5'b00000});
    repeat (2) @(negedge clk);
    chk_per = 1'b0;
    reset = 1'b0;
    tick_idx = -1;
    next_tick(n);
    check("restart_p0", big_o(),
          {10'd0, 10'd0, 5'b11101});
    chk_per = 1'b1;
    next_tick(n);
    check("restart_p1", big_o(),
          {10'd1, 10'd0, 5'b11101});
    next_tick(n);
    check("restart_sm_p2", sm_o(),
          {10'd2, 10'd0, 5'b00101});

    finish_now();
  end

endmodule
